// File: rtl/xgmac_cfg_pkg.sv
// xgmac_cfg_pkg: shared definitions for the XGMAC configuration sequencer.
//   - state_e      : sequencer FSM state encodings
//   - ERR_*        : err_code values reported on cfg_err
//   - CNT_W        : width of the shared timeout/poll-gap counter and poll counter
//   - table_addr() : register address of configuration write entry 0..15
//   - table_data() : value written for configuration write entry 0..15
package xgmac_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        GAP   = 3'd2,
        POLL  = 3'd3,
        PWAIT = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TMO  = 2'b01;  // no matching ack in time
    localparam logic [1:0] ERR_SLV  = 2'b10;  // slave answered with ip2bus_error
    localparam logic [1:0] ERR_POLL = 2'b11;  // status never became ready

    localparam int         CNT_W    = 16;
    localparam logic [3:0] IDX_POLL = 4'hF;   // err_idx reported for status-poll failures

    // Entries 0..3 bring up MAC TX, MAC RX, flow control and the MDIO master.
    // Spare slots point at a scratch location so a larger C_NUM_WR stays harmless.
    function automatic logic [31:0] table_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    table_addr = 32'h0000_0408;  // transmitter configuration
            4'd1:    table_addr = 32'h0000_0404;  // receiver configuration
            4'd2:    table_addr = 32'h0000_040C;  // flow control configuration
            4'd3:    table_addr = 32'h0000_0500;  // MDIO setup
            default: table_addr = 32'h0000_04FC;  // scratch
        endcase
    endfunction

    function automatic logic [31:0] table_data(input logic [3:0] idx);
        case (idx)
            4'd0:    table_data = 32'h1000_0000;  // TX enable
            4'd1:    table_data = 32'h1000_0000;  // RX enable
            4'd2:    table_data = 32'h6000_0000;  // honour + emit pause frames
            4'd3:    table_data = 32'h0000_0068;  // MDIO enable, clock divide 8
            default: table_data = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/xgmac_cfg_tmo.sv
// xgmac_cfg_tmo: loadable down-counter that saturates at zero. The sequencer
// uses it both as the ack timeout and as the idle gap between status polls.
//   clk/rst   : clock, synchronous active-high reset
//   load      : load load_val (wins over dec)
//   dec       : count down by one while non-zero
//   zero      : counter currently at zero
module xgmac_cfg_tmo
    import xgmac_cfg_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load, decrement or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/xgmac_cfg_seq.sv
// xgmac_cfg_seq: after MAC/PHY reset completes, writes C_NUM_WR configuration
// entries over the IPIF master port, then polls a status register until the
// bits in C_STATUS_MASK are all set.
//   bus2ip_clk/bus2ip_reset : clock, synchronous active-high reset
//   resetdone               : asynchronous ready level from the MAC/PHY
//   restart                 : one-cycle pulse, restarts the whole sequence
//   bus2ip_*                : IPIF master request (all registered)
//   ip2bus_*                : IPIF slave response
//   cfg_done/cfg_err        : sequence finished / failed
//   err_code/err_idx        : failure cause and failing table entry (F = poll)
//   status_q                : last status value read successfully
module xgmac_cfg_seq
    import xgmac_cfg_pkg::*;
#(
    parameter int          C_NUM_WR      = 4,
    parameter int          C_TIMEOUT     = 255,
    parameter int          C_POLL_GAP    = 1023,
    parameter int          C_MAX_POLL    = 64,
    parameter logic [31:0] C_STATUS_ADDR = 32'h0000_0600,
    parameter logic [31:0] C_STATUS_MASK = 32'h0000_0001
) (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_reset,
    input  logic        resetdone,
    input  logic        restart,
    output logic        bus2ip_cs,
    output logic        bus2ip_rnw,
    output logic [31:0] bus2ip_addr,
    output logic [31:0] bus2ip_data,
    input  logic [31:0] ip2bus_data,
    input  logic        ip2bus_wrack,
    input  logic        ip2bus_rdack,
    input  logic        ip2bus_error,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [1:0]  err_code,
    output logic [3:0]  err_idx,
    output logic [31:0] status_q
);

    // Counter reload values: a count of N cycles loads N-1 and expires at zero.
    localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(C_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(C_POLL_GAP - 1);
    localparam logic [CNT_W-1:0] MAX_POLL = CNT_W'(C_MAX_POLL);
    localparam logic [3:0]       LAST_IDX = 4'(C_NUM_WR - 1);

    state_e             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic               cs_q, cs_d;
    logic               rnw_q, rnw_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic               cfg_done_q, cfg_done_d;
    logic               cfg_err_q, cfg_err_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [3:0]         err_idx_q, err_idx_d;
    logic [31:0]        status_d;

    logic               rdy_s;
    logic               wr_ack_s;
    logic               rd_ack_s;
    logic [CNT_W-1:0]   poll_next_s;
    logic               tmo_load_s;
    logic [CNT_W-1:0]   tmo_val_s;
    logic               tmo_dec_s;
    logic               tmo_zero_s;

    assign rdy_s       = sync_q[1];
    // Only the ack that matches the current transfer direction is honoured.
    assign wr_ack_s    = cs_q & ~rnw_q & ip2bus_wrack;
    assign rd_ack_s    = cs_q &  rnw_q & ip2bus_rdack;
    assign poll_next_s = poll_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    xgmac_cfg_tmo #(.W(CNT_W)) u_tmo (
        .clk      (bus2ip_clk),
        .rst      (bus2ip_reset),
        .load     (tmo_load_s),
        .load_val (tmo_val_s),
        .dec      (tmo_dec_s),
        .zero     (tmo_zero_s)
    );

    // Sequencer next-state and next-output logic.
    always_comb begin
        sync_d     = {sync_q[0], resetdone};
        state_d    = state_q;
        idx_d      = idx_q;
        poll_cnt_d = poll_cnt_q;
        cs_d       = cs_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        cfg_done_d = cfg_done_q;
        cfg_err_d  = cfg_err_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        status_d   = status_q;
        tmo_load_s = 1'b0;
        tmo_val_s  = TMO_LOAD;
        tmo_dec_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (rdy_s) begin
                    state_d    = WR;
                    idx_d      = 4'd0;
                    poll_cnt_d = {CNT_W{1'b0}};
                    cs_d       = 1'b1;
                    rnw_d      = 1'b0;
                    addr_d     = table_addr(4'd0);
                    data_d     = table_data(4'd0);
                    tmo_load_s = 1'b1;
                end else begin
                    cs_d = 1'b0;
                end
            end
            WR: begin
                tmo_dec_s = 1'b1;
                if (wr_ack_s) begin
                    cs_d = 1'b0;
                    if (ip2bus_error) begin
                        state_d    = ERR;
                        cfg_err_d  = 1'b1;
                        err_code_d = ERR_SLV;
                        err_idx_d  = idx_q;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = POLL;   // first POLL cycle keeps cs low
                    end else begin
                        state_d = GAP;
                    end
                end else if (tmo_zero_s) begin
                    cs_d       = 1'b0;
                    state_d    = ERR;
                    cfg_err_d  = 1'b1;
                    err_code_d = ERR_TMO;
                    err_idx_d  = idx_q;
                end else begin
                    cs_d = 1'b1;
                end
            end
            GAP: begin
                // Address/data are precomputed from idx+1 so they are valid with cs.
                state_d    = WR;
                idx_d      = idx_q + 4'd1;
                cs_d       = 1'b1;
                rnw_d      = 1'b0;
                addr_d     = table_addr(idx_q + 4'd1);
                data_d     = table_data(idx_q + 4'd1);
                tmo_load_s = 1'b1;
            end
            POLL: begin
                if (!cs_q) begin
                    // Arriving straight from the last write: issue the read now.
                    cs_d       = 1'b1;
                    rnw_d      = 1'b1;
                    addr_d     = C_STATUS_ADDR;
                    data_d     = 32'h0000_0000;
                    tmo_load_s = 1'b1;
                end else begin
                    tmo_dec_s = 1'b1;
                    if (rd_ack_s) begin
                        cs_d = 1'b0;
                        if (ip2bus_error) begin
                            state_d    = ERR;
                            cfg_err_d  = 1'b1;
                            err_code_d = ERR_SLV;
                            err_idx_d  = IDX_POLL;
                        end else begin
                            status_d   = ip2bus_data;
                            poll_cnt_d = poll_next_s;
                            if ((ip2bus_data & C_STATUS_MASK) == C_STATUS_MASK) begin
                                state_d    = DONE;
                                cfg_done_d = 1'b1;
                            end else if (poll_next_s >= MAX_POLL) begin
                                state_d    = ERR;
                                cfg_err_d  = 1'b1;
                                err_code_d = ERR_POLL;
                                err_idx_d  = IDX_POLL;
                            end else begin
                                state_d    = PWAIT;
                                tmo_load_s = 1'b1;
                                tmo_val_s  = GAP_LOAD;
                            end
                        end
                    end else if (tmo_zero_s) begin
                        cs_d       = 1'b0;
                        state_d    = ERR;
                        cfg_err_d  = 1'b1;
                        err_code_d = ERR_TMO;
                        err_idx_d  = IDX_POLL;
                    end else begin
                        cs_d = 1'b1;
                    end
                end
            end
            PWAIT: begin
                tmo_dec_s = 1'b1;
                if (tmo_zero_s) begin
                    state_d    = POLL;
                    cs_d       = 1'b1;
                    rnw_d      = 1'b1;
                    addr_d     = C_STATUS_ADDR;
                    data_d     = 32'h0000_0000;
                    tmo_load_s = 1'b1;
                    tmo_val_s  = TMO_LOAD;
                end else begin
                    cs_d = 1'b0;
                end
            end
            DONE: begin
                if (!rdy_s) begin
                    state_d    = IDLE;
                    cfg_done_d = 1'b0;
                end else begin
                    cfg_done_d = 1'b1;
                end
            end
            ERR: begin
                cs_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
            end
        endcase

        // restart overrides everything above, including a same-cycle ack.
        if (restart) begin
            state_d    = IDLE;
            idx_d      = idx_q;
            cs_d       = 1'b0;
            cfg_done_d = 1'b0;
            cfg_err_d  = 1'b0;
            err_code_d = err_code_q;
            err_idx_d  = err_idx_q;
            status_d   = status_q;
            poll_cnt_d = {CNT_W{1'b0}};
            tmo_load_s = 1'b1;
            tmo_val_s  = {CNT_W{1'b0}};
            tmo_dec_s  = 1'b0;
        end else begin
            tmo_dec_s = tmo_dec_s & ~tmo_load_s;
        end
    end

    // Sequencer state, synchronizer and registered outputs.
    always_ff @(posedge bus2ip_clk) begin
        if (bus2ip_reset) begin
            state_q    <= IDLE;
            sync_q     <= 2'b00;
            idx_q      <= 4'd0;
            poll_cnt_q <= {CNT_W{1'b0}};
            cs_q       <= 1'b0;
            rnw_q      <= 1'b1;
            addr_q     <= 32'h0000_0000;
            data_q     <= 32'h0000_0000;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= 4'd0;
            status_q   <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            cs_q       <= cs_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            cfg_done_q <= cfg_done_d;
            cfg_err_q  <= cfg_err_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
            status_q   <= status_d;
        end
    end

    assign bus2ip_cs   = cs_q;
    assign bus2ip_rnw  = rnw_q;
    assign bus2ip_addr = addr_q;
    assign bus2ip_data = data_q;
    assign cfg_done    = cfg_done_q;
    assign cfg_err     = cfg_err_q;
    assign err_code    = err_code_q;
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_xgmac_cfg_seq.sv
// tb_xgmac_cfg_seq: table-driven bench for xgmac_cfg_seq. A slave model acks
// each transfer on its third cs cycle; each table row scripts the status
// values, a write entry that never acks and a write entry that errors, plus
// the expected final status outputs. Hand sequences cover restart and
// resetdone removal.
module tb_xgmac_cfg_seq;

    localparam int NUM_WR = 4;
    localparam int TMO    = 15;
    localparam int PGAP   = 8;
    localparam int MAXP   = 4;
    localparam int NVEC   = 7;

    logic        bus2ip_clk = 1'b0;
    logic        bus2ip_reset, resetdone, restart;
    logic        bus2ip_cs, bus2ip_rnw;
    logic [31:0] bus2ip_addr, bus2ip_data;
    logic [31:0] ip2bus_data;
    logic        ip2bus_wrack, ip2bus_rdack, ip2bus_error;
    logic        cfg_done, cfg_err;
    logic [1:0]  err_code;
    logic [3:0]  err_idx;
    logic [31:0] status_q;

    always #5 bus2ip_clk = ~bus2ip_clk;

    xgmac_cfg_seq #(
        .C_NUM_WR      (NUM_WR),
        .C_TIMEOUT     (TMO),
        .C_POLL_GAP    (PGAP),
        .C_MAX_POLL    (MAXP),
        .C_STATUS_ADDR (32'h0000_0600),
        .C_STATUS_MASK (32'h0000_0001)
    ) dut (
        .bus2ip_clk   (bus2ip_clk),
        .bus2ip_reset (bus2ip_reset),
        .resetdone    (resetdone),
        .restart      (restart),
        .bus2ip_cs    (bus2ip_cs),
        .bus2ip_rnw   (bus2ip_rnw),
        .bus2ip_addr  (bus2ip_addr),
        .bus2ip_data  (bus2ip_data),
        .ip2bus_data  (ip2bus_data),
        .ip2bus_wrack (ip2bus_wrack),
        .ip2bus_rdack (ip2bus_rdack),
        .ip2bus_error (ip2bus_error),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .err_code     (err_code),
        .err_idx      (err_idx),
        .status_q     (status_q)
    );

    // Expected configuration writes, in order.
    logic [31:0] exp_addr [NUM_WR] = '{32'h0000_0408, 32'h0000_0404, 32'h0000_040C, 32'h0000_0500};
    logic [31:0] exp_data [NUM_WR] = '{32'h1000_0000, 32'h1000_0000, 32'h6000_0000, 32'h0000_0068};

    typedef struct {
        string       name;
        logic [31:0] s0, s1, s2;   // status for read 1, read 2, read 3 and later
        int          noack;        // write entry that is never acked (-1: none)
        int          errent;       // write entry acked with error (-1: none)
        int          budget;       // max cycles from resetdone to done/err
        logic        e_done, e_err;
        logic [1:0]  e_code;
        logic [3:0]  e_idx;
        int          e_wr, e_rd, e_len;
        logic [31:0] e_status;
    } vec_t;

    vec_t vecs [NVEC];

    int checks   = 0;
    int failures = 0;

    // slave model / observation state
    int          cs_cnt, idle_cnt, n_wr, n_rd, cyc, last_len;
    bit          order_ok, gap_ok, stable_ok, first_txn, last_was_read;
    logic [31:0] txn_addr, txn_data, cur_s0, cur_s1, cur_s2;
    logic        txn_rnw;
    int          cur_noack, cur_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One negedge step of the slave: observe the request, drive the response.
    task automatic slave_step();
        int gap_exp;
        ip2bus_wrack = 1'b0;
        ip2bus_rdack = 1'b0;
        ip2bus_error = 1'b0;
        ip2bus_data  = 32'h0000_0000;
        if (bus2ip_cs) begin
            cs_cnt++;
            if (cs_cnt == 1) begin
                if (!first_txn) begin
                    gap_exp = (bus2ip_rnw && last_was_read) ? PGAP : 1;
                    if (idle_cnt != gap_exp) gap_ok = 1'b0;
                end
                first_txn = 1'b0;
                txn_addr  = bus2ip_addr;
                txn_data  = bus2ip_data;
                txn_rnw   = bus2ip_rnw;
                if (bus2ip_rnw) begin
                    n_rd++;
                    if (bus2ip_addr != 32'h0000_0600 || n_wr != NUM_WR) order_ok = 1'b0;
                end else begin
                    if (n_wr >= NUM_WR || n_rd != 0) order_ok = 1'b0;
                    else if (bus2ip_addr != exp_addr[n_wr] || bus2ip_data != exp_data[n_wr]) order_ok = 1'b0;
                    n_wr++;
                end
                last_was_read = bus2ip_rnw;
            end else if (bus2ip_addr != txn_addr || bus2ip_rnw != txn_rnw ||
                         (!txn_rnw && bus2ip_data != txn_data)) begin
                stable_ok = 1'b0;
            end
            if (cs_cnt == 3) begin
                if (txn_rnw) begin
                    ip2bus_rdack = 1'b1;
                    ip2bus_data  = (n_rd == 1) ? cur_s0 : (n_rd == 2) ? cur_s1 : cur_s2;
                end else if (n_wr - 1 != cur_noack) begin
                    ip2bus_wrack = 1'b1;
                    ip2bus_error = (n_wr - 1 == cur_err);
                end
            end
            idle_cnt = 0;
        end else begin
            if (cs_cnt != 0) last_len = cs_cnt;
            cs_cnt = 0;
            idle_cnt++;
        end
    endtask

    task automatic reset_dut();
        resetdone    = 1'b0;
        restart      = 1'b0;
        bus2ip_reset = 1'b1;
        ip2bus_wrack = 1'b0;
        ip2bus_rdack = 1'b0;
        ip2bus_error = 1'b0;
        ip2bus_data  = 32'h0000_0000;
        repeat (3) @(negedge bus2ip_clk);
        bus2ip_reset = 1'b0;
        cs_cnt = 0; idle_cnt = 0; n_wr = 0; n_rd = 0; last_len = 0;
        order_ok = 1'b1; gap_ok = 1'b1; stable_ok = 1'b1;
        first_txn = 1'b1; last_was_read = 1'b0;
    endtask

    task automatic rst_check(input string tag);
        bus2ip_reset = 1'b1;
        restart      = 1'b1;   // reset must win over restart
        repeat (2) @(negedge bus2ip_clk);
        chk({tag, "_ctl"}, {bus2ip_cs, bus2ip_rnw, cfg_done, cfg_err, err_code, err_idx}, 10'b01_0000_0000);
        chk({tag, "_addr"}, bus2ip_addr, 32'h0000_0000);
        chk({tag, "_data"}, bus2ip_data, 32'h0000_0000);
        chk({tag, "_status"}, status_q, 32'h0000_0000);
        bus2ip_reset = 1'b0;
        restart      = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        reset_dut();
        cur_s0 = v.s0; cur_s1 = v.s1; cur_s2 = v.s2;
        cur_noack = v.noack; cur_err = v.errent;
        resetdone = 1'b1;
        cyc = 0;
        while (!(cfg_done || cfg_err) && cyc < 500) begin
            @(negedge bus2ip_clk);
            cyc++;
            slave_step();
        end
        chk({v.name, "_in_time"}, (cyc <= v.budget) ? 1 : 0, 1);
        chk({v.name, "_done"}, cfg_done, v.e_done);
        chk({v.name, "_err"}, cfg_err, v.e_err);
        chk({v.name, "_err_code"}, err_code, v.e_code);
        chk({v.name, "_err_idx"}, err_idx, v.e_idx);
        chk({v.name, "_writes"}, n_wr, v.e_wr);
        chk({v.name, "_reads"}, n_rd, v.e_rd);
        chk({v.name, "_status"}, status_q, v.e_status);
        chk({v.name, "_order"}, order_ok, 1'b1);
        chk({v.name, "_gaps"}, gap_ok, 1'b1);
        chk({v.name, "_stable"}, stable_ok, 1'b1);
        chk({v.name, "_last_cs_len"}, last_len, v.e_len);
        chk({v.name, "_cs_low"}, bus2ip_cs, 1'b0);
    endtask

    initial begin
        bit seen;
        //             name      s0            s1            s2            noack err budget done err code   idx   wr rd len status
        vecs[0] = '{"basic",   32'h0000_0001, 32'h0000_0001, 32'h0000_0001, -1, -1,  28, 1'b1, 1'b0, 2'b00, 4'h0, 4, 1, 3,  32'h0000_0001};
        vecs[1] = '{"poll3",   32'h0000_0000, 32'h0000_0000, 32'h0000_0001, -1, -1, 400, 1'b1, 1'b0, 2'b00, 4'h0, 4, 3, 3,  32'h0000_0001};
        vecs[2] = '{"tmo_e2",  32'h0000_0001, 32'h0000_0001, 32'h0000_0001,  2, -1, 400, 1'b0, 1'b1, 2'b01, 4'h2, 3, 0, 15, 32'h0000_0000};
        vecs[3] = '{"slverr0", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, -1,  0, 400, 1'b0, 1'b1, 2'b10, 4'h0, 1, 0, 3,  32'h0000_0000};
        vecs[4] = '{"pollmax", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1, -1, 400, 1'b0, 1'b1, 2'b11, 4'hF, 4, 4, 3,  32'h0000_0000};
        vecs[5] = '{"mask",    32'hFFFF_FFFE, 32'h8000_0003, 32'h0000_0000, -1, -1, 400, 1'b1, 1'b0, 2'b00, 4'h0, 4, 2, 3,  32'h8000_0003};
        vecs[6] = '{"slverr3", 32'h0000_0001, 32'h0000_0001, 32'h0000_0001, -1,  3, 400, 1'b0, 1'b1, 2'b10, 4'h3, 4, 0, 3,  32'h0000_0000};

        bus2ip_reset = 1'b1; resetdone = 1'b0; restart = 1'b0;
        ip2bus_wrack = 1'b0; ip2bus_rdack = 1'b0; ip2bus_error = 1'b0;
        ip2bus_data  = 32'h0000_0000;
        rst_check("rst_init");

        for (int i = 0; i < NVEC; i++) run_vec(i);

        // restart out of ERR clears cfg_err on the next cycle
        restart = 1'b1;
        @(negedge bus2ip_clk);
        restart = 1'b0;
        chk("restart_err_clr", {cfg_err, cfg_done, bus2ip_cs}, 3'b000);

        // reset clears a latched error code / index
        rst_check("rst_after_err");

        // resetdone removal from DONE: cfg_done clears after the 2-flop sync + 1
        run_vec(0);
        resetdone = 1'b0;
        repeat (2) @(negedge bus2ip_clk);
        chk("done_hold_sync", cfg_done, 1'b1);
        @(negedge bus2ip_clk);
        chk("done_clr", cfg_done, 1'b0);

        // restart coincident with wrack: ack ignored, restarts at entry 0
        reset_dut();
        resetdone = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge bus2ip_clk);
            seen = bus2ip_cs;
        end
        chk("rs_cs_rise", seen, 1'b1);
        ip2bus_rdack = 1'b1;             // wrong-direction ack
        @(negedge bus2ip_clk);
        ip2bus_rdack = 1'b0;
        chk("rs_rdack_ignored", {bus2ip_cs, bus2ip_rnw}, 2'b10);
        ip2bus_wrack = 1'b1;
        restart      = 1'b1;
        @(negedge bus2ip_clk);
        ip2bus_wrack = 1'b0;
        restart      = 1'b0;
        chk("rs_cs_drop", {bus2ip_cs, cfg_done, cfg_err}, 3'b000);
        @(negedge bus2ip_clk);
        chk("rs_cs_again", {bus2ip_cs, bus2ip_rnw}, 2'b10);
        chk("rs_idx0_addr", bus2ip_addr, exp_addr[0]);
        chk("rs_idx0_data", bus2ip_data, exp_data[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xgmac_cfg_seq.md
XGMAC_CFG_SEQ -- requirements
Module: xgmac_cfg_seq

Interface
REQ-001 The block SHALL have parameter C_NUM_WR, default 4, giving the number of config-table write entries (1..16).
REQ-002 The block SHALL have parameter C_TIMEOUT, default 255, giving the maximum wait in cycles from cs assertion to ack.
REQ-003 The block SHALL have parameter C_POLL_GAP, default 1023, giving the idle cycles between status reads.
REQ-004 The block SHALL have parameter C_MAX_POLL, default 64, giving the maximum number of status reads before failure.
REQ-005 The block SHALL have parameter C_STATUS_ADDR, default 32'h0000_0600, giving the status register address.
REQ-006 The block SHALL have parameter C_STATUS_MASK, default 32'h0000_0001, giving the status bits that must all read 1.
REQ-007 The block SHALL have port bus2ip_clk, input, 1 bit: the single clock.
REQ-008 The block SHALL have port bus2ip_reset, input, 1 bit: synchronous, active-high reset.
REQ-009 The block SHALL have port resetdone, input, 1 bit: asynchronous MAC/PHY ready level.
REQ-010 The block SHALL have port restart, input, 1 bit: single-cycle pulse that restarts the sequence.
REQ-011 The block SHALL have output ports bus2ip_cs (1), bus2ip_rnw (1), bus2ip_addr (32) and bus2ip_data (32): the IPIF master.
REQ-012 The block SHALL have input ports ip2bus_data (32), ip2bus_wrack (1), ip2bus_rdack (1) and ip2bus_error (1): the IPIF response.
REQ-013 The block SHALL have outputs cfg_done (1), cfg_err (1), err_code (2) and err_idx (4): sequence status.
REQ-014 The block SHALL have output status_q (32): the last captured status read.

Function
REQ-015 resetdone SHALL pass through a 2-flop synchronizer before use (rdy_s).
REQ-016 The FSM SHALL have states IDLE, WR, GAP, POLL, PWAIT, DONE and ERR.
REQ-017 In IDLE, when rdy_s=1, the FSM SHALL load idx=0 and go to WR on the next cycle.
REQ-018 In WR, the block SHALL drive cs=1, rnw=0, addr=table_addr[idx] and data=table_data[idx], holding them stable until ack.
REQ-019 In WR, on wrack with error=0 the FSM SHALL go to GAP; if idx==C_NUM_WR-1 it SHALL go to POLL instead.
REQ-020 GAP SHALL last exactly 1 cycle with cs=0, increment idx, then return to WR.
REQ-021 In POLL, the block SHALL drive cs=1, rnw=1 and addr=C_STATUS_ADDR; on rdack it SHALL capture ip2bus_data into status_q and increment poll_cnt.
REQ-022 On rdack, if (data & C_STATUS_MASK)==C_STATUS_MASK the FSM SHALL go to DONE.
REQ-023 On rdack with the mask not satisfied and poll_cnt<C_MAX_POLL, the FSM SHALL go to PWAIT; once poll_cnt reaches C_MAX_POLL it SHALL go to ERR instead.
REQ-024 PWAIT SHALL hold cs=0 for C_POLL_GAP cycles, then go to POLL.
REQ-025 The timeout counter SHALL clear on entry to WR/POLL; if it reaches C_TIMEOUT with no matching ack, the FSM SHALL go to ERR with err_code=2'b01.
REQ-026 An ack with ip2bus_error=1 SHALL go to ERR with err_code=2'b10.
REQ-027 A poll exhaustion SHALL set err_code=2'b11.
REQ-028 On every ERR entry, err_idx SHALL hold idx; poll failures SHALL report err_idx=4'hF.
REQ-029 Only the ack matching rnw SHALL count; wrack during a read, rdack during a write, and any ack while cs=0 SHALL be ignored.
REQ-030 bus2ip_cs SHALL deassert in the cycle after the accepted ack; there SHALL be no back-to-back cs cycles.
REQ-031 In DONE, cfg_done SHALL be 1; if rdy_s falls, the FSM SHALL go to IDLE and cfg_done SHALL clear the next cycle.
REQ-032 In ERR, cfg_err SHALL be 1, and the FSM SHALL stay in ERR until restart.
REQ-033 restart in any state SHALL force IDLE the next cycle, drop cs, and clear cfg_done, cfg_err, poll_cnt and the timeout counter; restart SHALL take priority over a simultaneous ack.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On bus2ip_reset=1 the block SHALL set: state=IDLE; cs=0; rnw=1; addr=0; data=0; cfg_done=0; cfg_err=0; err_code=0; err_idx=0; status_q=0; synchronizer=0; all counters=0.
REQ-036 Reset SHALL be synchronous and take priority over restart.

Structure
REQ-037 Shared include xgmac_cfg_pkg SHALL hold the state encodings, the err_code constants, and table_addr/table_data functions indexed 0..15 (MAC TX/RX config, flow control, MDIO setup).
REQ-038 The block SHALL use one sub-module, xgmac_cfg_tmo, a loadable down-counter shared between the timeout and PWAIT counts.

Verification
REQ-039 Scenario: resetdone rises, slave acks writes after 3 cycles, status reads 0x1 -> 4 writes in table order, then 1 read; cfg_done=1 within 4*(3+2)+5+3 cycles.
REQ-040 Scenario: status reads 0x0 twice, then 0x1 (C_POLL_GAP=8) -> exactly 3 reads, gaps of 8 idle cycles, then cfg_done=1.
REQ-041 Scenario: no wrack on entry 2 (C_TIMEOUT=15) -> cs drops after 15 cycles; cfg_err=1, err_code=01, err_idx=2.
REQ-042 Scenario: wrack with ip2bus_error=1 on entry 0 -> cfg_err=1, err_code=10, err_idx=0.
REQ-043 Scenario: status always 0 (C_MAX_POLL=4) -> 4 reads, then err_code=11, err_idx=F.
REQ-044 Scenario: restart pulse coincident with wrack mid-write -> IDLE next cycle; ack ignored; sequence restarts at idx=0.
